tpn_serializer: RTL and testbench
=================================

// Module: tpn_serializer
// PURPOSE
//  Downstream of the per-block 4-pattern page comparator. Takes one block's
//  8-bit page-match mask per handshake and serializes the matching global
//  true page numbers (TPN = blk_idx*PPB + page) one per cycle, lowest page
//  first, over a valid/ready stream. Flags the last TPN of a scan and keeps
//  a per-scan hit count. Replaces the bit-offset packing of the TPN array.
// PARAMETERS
//  NOB    3  blocks per scan (input vector 288b / 96b per block)
//  PPB    8  pages (comparators) per block; width of blk_mask
//  NOB_W  2  width of blk_idx, >= clog2(NOB)
//  PPB_W  3  width of page index, = clog2(PPB)
//  NOP_W  5  width of tpn, >= clog2(NOB*PPB)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-low
//  blk_valid  in   1      block result valid
//  blk_ready  out  1      block result accepted when blk_valid&blk_ready
//  blk_idx    in   NOB_W  block index of this result
//  blk_mask   in   PPB    bit p = page p of block matched any pattern
//  blk_last   in   1      this is the final block of the scan
//  tpn_valid  out  1      tpn holds a valid true page number
//  tpn_ready  in   1      consumer takes tpn when tpn_valid&tpn_ready
//  tpn        out  NOP_W  global true page number
//  tpn_last   out  1      with tpn_valid: final TPN of the scan
//  hit_count  out  NOP_W+1 TPNs emitted in current/last scan (0..NOB*PPB)
//  done       out  1      one-cycle pulse: scan fully drained
//  err        out  1      sticky: a block with blk_idx >= NOB was received
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE; blk_ready=0 while rst=0, tpn_valid=0,
//    tpn=0, tpn_last=0, hit_count=0, done=0, err=0, internal mask/idx/last=0.
//  - FSM IDLE: blk_ready=1. DRAIN: blk_ready=0. No accept in DRAIN.
//  - Accept (IDLE, blk_valid=1): latch idx, mask, last.
//    * blk_idx >= NOB: block dropped, err<=1 (sticky until reset), stay IDLE,
//      no TPN, no done even if blk_last.
//    * mask==0: stay IDLE; if blk_last, done=1 next cycle.
//    * mask!=0: go DRAIN; first tpn_valid the cycle after accept (latency 1).
//  - If the accepted block is the first of a scan (previous scan ended with
//    done, or first after reset), hit_count clears to 0 before counting.
//  - DRAIN: tpn = idx*PPB + (lowest set bit of remaining mask), registered.
//    tpn_valid stays 1, tpn stable, until tpn_ready=1 (no retraction).
//    On handshake: clear that bit, hit_count+1, present next set bit in the
//    next cycle (back-to-back: 1 TPN/cycle with tpn_ready held 1).
//  - tpn_last = latched last & (exactly one bit remains in mask).
//  - Handshake on final bit: tpn_valid=0 next cycle, IDLE; if last, done=1
//    that same next cycle for one cycle. Block throughput: popcount(mask)+1
//    cycles per nonempty block.
//  - Arithmetic: idx*PPB+page computed in NOP_W bits; max NOB*PPB-1 fits.
//    hit_count never exceeds NOB*PPB; no wrap.
//  - Blocks need not arrive in order; TPNs follow arrival order.
//  - rst low mid-DRAIN: all pending TPNs discarded, outputs to reset values.
// TESTING
//  1 blocks 0,1,2 masks 8'h81,8'h00,8'h10(last), tpn_ready=1 -> tpn 0,7,20;
//    last on 20; hit_count=3; done 1 cycle after 20 handshake.
//  2 block 1 mask 8'hFF last, tpn_ready=1 -> tpn 8..15 on 8 consecutive
//    cycles, blk_ready=0 throughout, tpn_last only on 15, hit_count=8.
//  3 backpressure: mask 8'h06 block 2, tpn_ready toggles 0/1 -> tpn 17 held
//    stable while ready=0, then 18; no loss or duplicate.
//  4 single block 0 mask 8'h00 last -> no tpn_valid; done pulse next cycle;
//    hit_count=0; next scan's first block restarts count from 0.
//  5 blk_idx=3 mask 8'hFF -> err=1, no TPN, blk_ready stays 1; err holds
//    until rst.
//  6 rst low after 2nd of 5 TPNs -> tpn_valid=0, hit_count=0 immediately;
//    after release, new block accepted normally.

Source files
------------

// File: rtl/tpn_serializer_if.sv
// tpn_serializer_if: block-mask input and TPN stream output bundle for tpn_serializer
interface tpn_serializer_if #(
    parameter int PPB   = 8,
    parameter int NOB_W = 2,
    parameter int NOP_W = 5
);
    logic             blk_valid;
    logic             blk_ready;
    logic [NOB_W-1:0] blk_idx;
    logic [PPB-1:0]   blk_mask;
    logic             blk_last;
    logic             tpn_valid;
    logic             tpn_ready;
    logic [NOP_W-1:0] tpn;
    logic             tpn_last;
    logic [NOP_W:0]   hit_count;
    logic             done;
    logic             err;
    modport master (
        output blk_valid, blk_idx, blk_mask, blk_last, tpn_ready,
        input  blk_ready, tpn_valid, tpn, tpn_last, hit_count, done, err
    );
    modport slave (
        input  blk_valid, blk_idx, blk_mask, blk_last, tpn_ready,
        output blk_ready, tpn_valid, tpn, tpn_last, hit_count, done, err
    );
endinterface

// File: rtl/tpn_serializer.sv
// tpn_serializer: turns per-block page-match masks into a stream of global TPNs, lowest page first
module tpn_serializer #(
    parameter int NOB   = 3,
    parameter int PPB   = 8,
    parameter int NOB_W = 2,
    parameter int PPB_W = 3,
    parameter int NOP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    tpn_serializer_if.slave  io_bus
);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t           r_state, w_next;
    logic [NOB_W-1:0] r_idx;
    logic [PPB-1:0]   r_mask;
    logic             r_last, r_tpn_valid, r_tpn_last, r_done, r_err, r_new_scan;
    logic [NOP_W-1:0] r_tpn;
    logic [NOP_W:0]   r_hit;
    logic             w_acc, w_bad, w_hs;
    logic [PPB-1:0]   w_rem;

    function automatic logic [PPB_W-1:0] lsb_idx(input logic [PPB-1:0] m);
        lsb_idx = '0;
        for (int p = PPB - 1; p >= 0; p--)
            if (m[p]) lsb_idx = PPB_W'(p);
    endfunction

    function automatic logic one_hot(input logic [PPB-1:0] m);
        return m != '0 && (m & (m - 1'b1)) == '0;
    endfunction

    function automatic logic [NOP_W-1:0] tpn_of(input logic [NOB_W-1:0] idx, input logic [PPB-1:0] m);
        return NOP_W'(idx) * NOP_W'(PPB) + NOP_W'(lsb_idx(m));
    endfunction

    assign io_bus.blk_ready = rst && r_state == IDLE;
    assign io_bus.tpn_valid = r_tpn_valid;
    assign io_bus.tpn       = r_tpn;
    assign io_bus.tpn_last  = r_tpn_last;
    assign io_bus.hit_count = r_hit;
    assign io_bus.done      = r_done;
    assign io_bus.err       = r_err;
    assign w_acc = io_bus.blk_valid && io_bus.blk_ready;
    assign w_bad = {1'b0, io_bus.blk_idx} >= (NOB_W + 1)'(NOB);
    assign w_hs  = r_tpn_valid && io_bus.tpn_ready;
    // remaining mask once the lowest set bit has been handed off
    assign w_rem = r_mask & (r_mask - 1'b1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_acc && !w_bad && io_bus.blk_mask != '0) w_next = DRAIN;
        if (r_state == DRAIN && w_hs && w_rem == '0) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx       <= '0;
            r_mask      <= '0;
            r_last      <= 1'b0;
            r_tpn_valid <= 1'b0;
            r_tpn_last  <= 1'b0;
            r_tpn       <= '0;
            r_hit       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_new_scan  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_acc) begin
                r_idx  <= io_bus.blk_idx;
                r_mask <= io_bus.blk_mask;
                r_last <= io_bus.blk_last;
                if (w_bad) begin
                    r_err <= 1'b1;
                end else begin
                    if (r_new_scan) begin
                        r_hit      <= '0;
                        r_new_scan <= 1'b0;
                    end
                    if (io_bus.blk_mask != '0) begin
                        r_tpn_valid <= 1'b1;
                        r_tpn       <= tpn_of(io_bus.blk_idx, io_bus.blk_mask);
                        r_tpn_last  <= io_bus.blk_last && one_hot(io_bus.blk_mask);
                    end else if (io_bus.blk_last) begin
                        r_done     <= 1'b1;
                        r_new_scan <= 1'b1;
                    end
                end
            end
            if (w_hs) begin
                r_mask <= w_rem;
                r_hit  <= r_hit + 1'b1;
                if (w_rem != '0) begin
                    r_tpn      <= tpn_of(r_idx, w_rem);
                    r_tpn_last <= r_last && one_hot(w_rem);
                end else begin
                    r_tpn_valid <= 1'b0;
                    r_tpn_last  <= 1'b0;
                    if (r_last) begin
                        r_done     <= 1'b1;
                        r_new_scan <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tpn_serializer.sv
// tb_tpn_serializer: directed vectors for tpn_serializer with hand-computed expectations
module tb_tpn_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [5:0] q[$];

    tpn_serializer_if #(.PPB(8), .NOB_W(2), .NOP_W(5)) bus ();

    tpn_serializer #(.NOB(3), .PPB(8), .NOB_W(2), .PPB_W(3), .NOP_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst && bus.tpn_valid && bus.tpn_ready) q.push_back({bus.tpn_last, bus.tpn});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send_blk(input logic [1:0] idx, input logic [7:0] m, input logic l);
        int n = 0;
        @(negedge clk);
        while (!bus.blk_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.blk_ready) chk("blk_ready_timeout", 32'(bus.blk_ready), 1);
        bus.blk_valid = 1'b1;
        bus.blk_idx   = idx;
        bus.blk_mask  = m;
        bus.blk_last  = l;
        @(posedge clk);
        #1 bus.blk_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.blk_valid = 1'b0;
        bus.blk_idx   = '0;
        bus.blk_mask  = '0;
        bus.blk_last  = 1'b0;
        bus.tpn_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_blk_ready", 32'(bus.blk_ready), 0);
        chk("rst_tpn_valid", 32'(bus.tpn_valid), 0);
        chk("rst_tpn", 32'(bus.tpn), 0);
        chk("rst_hit", 32'(bus.hit_count), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("idle_blk_ready", 32'(bus.blk_ready), 1);

        // 1: three blocks, sparse masks
        q.delete();
        send_blk(2'd0, 8'h81, 1'b0);
        send_blk(2'd1, 8'h00, 1'b0);
        send_blk(2'd2, 8'h10, 1'b1);
        @(negedge clk);
        chk("t1_tpn20", 32'(bus.tpn), 20);
        chk("t1_last20", 32'(bus.tpn_last), 1);
        @(negedge clk);
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_valid_off", 32'(bus.tpn_valid), 0);
        chk("t1_hit", 32'(bus.hit_count), 3);
        chk("t1_qsize", 32'(q.size()), 3);
        if (q.size() == 3) begin
            chk("t1_q0", 32'(q[0]), 0);
            chk("t1_q1", 32'(q[1]), 7);
            chk("t1_q2", 32'(q[2]), 52);
        end

        // 2: full mask back-to-back
        send_blk(2'd1, 8'hFF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_valid", 32'(bus.tpn_valid), 1);
            chk("t2_tpn", 32'(bus.tpn), 32'(8 + i));
            chk("t2_last", 32'(bus.tpn_last), 32'(i == 7));
            chk("t2_blk_ready", 32'(bus.blk_ready), 0);
        end
        @(negedge clk);
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_hit", 32'(bus.hit_count), 8);
        chk("t2_blk_ready_back", 32'(bus.blk_ready), 1);
        @(negedge clk);
        chk("t2_done_pulse", 32'(bus.done), 0);

        // 3: backpressure
        q.delete();
        bus.tpn_ready = 1'b0;
        send_blk(2'd2, 8'h06, 1'b1);
        @(negedge clk);
        chk("t3_tpn17_a", 32'(bus.tpn), 17);
        chk("t3_valid_a", 32'(bus.tpn_valid), 1);
        @(posedge clk);
        @(negedge clk);
        chk("t3_tpn17_b", 32'(bus.tpn), 17);
        @(posedge clk);
        #1 bus.tpn_ready = 1'b1;
        @(negedge clk);
        chk("t3_tpn17_c", 32'(bus.tpn), 17);
        @(posedge clk);
        #1 bus.tpn_ready = 1'b0;
        @(negedge clk);
        chk("t3_tpn18_a", 32'(bus.tpn), 18);
        chk("t3_last18", 32'(bus.tpn_last), 1);
        @(posedge clk);
        @(negedge clk);
        chk("t3_tpn18_b", 32'(bus.tpn), 18);
        chk("t3_valid_b", 32'(bus.tpn_valid), 1);
        @(posedge clk);
        #1 bus.tpn_ready = 1'b1;
        @(negedge clk);
        chk("t3_tpn18_c", 32'(bus.tpn), 18);
        @(negedge clk);
        chk("t3_valid_off", 32'(bus.tpn_valid), 0);
        chk("t3_done", 32'(bus.done), 1);
        chk("t3_hit", 32'(bus.hit_count), 2);
        chk("t3_qsize", 32'(q.size()), 2);
        if (q.size() == 2) begin
            chk("t3_q0", 32'(q[0]), 17);
            chk("t3_q1", 32'(q[1]), 50);
        end

        // 4: empty last block, then count restarts per scan
        send_blk(2'd0, 8'h00, 1'b1);
        @(negedge clk);
        chk("t4_done", 32'(bus.done), 1);
        chk("t4_valid", 32'(bus.tpn_valid), 0);
        chk("t4_hit", 32'(bus.hit_count), 0);
        send_blk(2'd0, 8'h01, 1'b0);
        @(negedge clk);
        chk("t4_tpn0", 32'(bus.tpn), 0);
        send_blk(2'd2, 8'h01, 1'b1);
        @(negedge clk);
        chk("t4_tpn16", 32'(bus.tpn), 16);
        chk("t4_last16", 32'(bus.tpn_last), 1);
        @(negedge clk);
        chk("t4_done2", 32'(bus.done), 1);
        chk("t4_hit2", 32'(bus.hit_count), 2);
        send_blk(2'd1, 8'h02, 1'b1);
        @(negedge clk);
        chk("t4_tpn9", 32'(bus.tpn), 9);
        chk("t4_hit_restart", 32'(bus.hit_count), 0);
        @(negedge clk);
        chk("t4_hit3", 32'(bus.hit_count), 1);

        // 5: out-of-range block index
        send_blk(2'd3, 8'hFF, 1'b1);
        @(negedge clk);
        chk("t5_err", 32'(bus.err), 1);
        chk("t5_valid", 32'(bus.tpn_valid), 0);
        chk("t5_blk_ready", 32'(bus.blk_ready), 1);
        chk("t5_no_done", 32'(bus.done), 0);
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", 32'(bus.err), 1);
        chk("t5_valid_still", 32'(bus.tpn_valid), 0);

        // 6: reset in the middle of a drain
        send_blk(2'd0, 8'h1F, 1'b1);
        @(negedge clk);
        chk("t6_tpn0", 32'(bus.tpn), 0);
        @(negedge clk);
        chk("t6_tpn1", 32'(bus.tpn), 1);
        @(negedge clk);
        chk("t6_tpn2", 32'(bus.tpn), 2);
        chk("t6_hit2", 32'(bus.hit_count), 2);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.tpn_valid), 0);
        chk("t6_rst_hit", 32'(bus.hit_count), 0);
        chk("t6_rst_tpn", 32'(bus.tpn), 0);
        chk("t6_rst_err", 32'(bus.err), 0);
        chk("t6_rst_blk_ready", 32'(bus.blk_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        send_blk(2'd2, 8'h40, 1'b1);
        @(negedge clk);
        chk("t6_tpn22", 32'(bus.tpn), 22);
        chk("t6_last22", 32'(bus.tpn_last), 1);
        @(negedge clk);
        chk("t6_done", 32'(bus.done), 1);
        chk("t6_hit", 32'(bus.hit_count), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
